// File: rtl/demux_stream_n.sv
// Registered 1-to-N stream demultiplexer with broadcast mode and a saturating
// counter of words whose select falls outside the channel range.
module demux_stream_n #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 8,
    parameter int SEL_W    = 3
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic [WIDTH-1:0]          in_data,
    input  logic [SEL_W-1:0]          in_sel,
    input  logic                      in_bcast,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic [CHANNELS*WIDTH-1:0] out_data,
    output logic [CHANNELS-1:0]       out_valid,
    input  logic [CHANNELS-1:0]       out_ready,
    output logic [7:0]                drop_count
);

    logic [CHANNELS-1:0]       vld_q, vld_d;
    logic [CHANNELS*WIDTH-1:0] data_q, data_d;
    logic [7:0]                drop_q, drop_d;

    logic [CHANNELS-1:0] free_w;
    logic [CHANNELS-1:0] dec_w;
    logic [CHANNELS-1:0] load_w;
    logic                in_range_w;
    logic                accept_w;
    logic                drop_inc_w;

    // An out-of-range select shifts the single one off the top, leaving no hit.
    assign dec_w      = {{(CHANNELS-1){1'b0}}, 1'b1} << in_sel;
    assign in_range_w = (32'(in_sel) < CHANNELS);
    assign free_w     = ~vld_q | out_ready;

    always_comb begin
        in_ready = 1'b0;
        if (!enable)
            in_ready = 1'b0;
        else if (in_bcast)
            in_ready = &free_w;
        else if (in_range_w)
            in_ready = |(free_w & dec_w);
        else
            in_ready = 1'b1;
    end

    assign accept_w   = in_valid && in_ready;
    assign load_w     = accept_w ? (in_bcast ? {CHANNELS{1'b1}} : dec_w) : '0;
    assign drop_inc_w = accept_w && !in_bcast && !in_range_w;

    // A load wins over a drain, so a busy channel can accept one word per cycle.
    always_comb begin
        vld_d  = load_w | (vld_q & ~out_ready);
        data_d = data_q;
        for (int i = 0; i < CHANNELS; i++) begin
            if (load_w[i])
                data_d[i*WIDTH +: WIDTH] = in_data;
        end
        drop_d = drop_q;
        if (drop_inc_w && (drop_q != 8'hFF))
            drop_d = drop_q + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_q  <= '0;
            data_q <= '0;
            drop_q <= '0;
        end else begin
            vld_q  <= vld_d;
            data_q <= data_d;
            drop_q <= drop_d;
        end
    end

    assign out_valid  = vld_q;
    assign out_data   = data_q;
    assign drop_count = drop_q;

endmodule

// File: tb/tb_demux_stream_n.sv
// Directed bench for demux_stream_n: an 8-channel instance for the main
// behaviour and a 6-channel instance for out-of-range drop counting.
module tb_demux_stream_n;

    logic        clk = 1'b0;
    logic        reset;

    logic        enable, in_bcast, in_valid, in_ready;
    logic [7:0]  in_data;
    logic [2:0]  in_sel;
    logic [63:0] out_data;
    logic [7:0]  out_valid, out_ready;
    logic [7:0]  drop_count;

    logic        b_enable, b_bcast, b_valid, b_ready;
    logic [7:0]  b_data;
    logic [2:0]  b_sel;
    logic [47:0] b_out_data;
    logic [5:0]  b_out_valid, b_out_ready;
    logic [7:0]  b_drop;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    demux_stream_n #(.WIDTH(8), .CHANNELS(8), .SEL_W(3)) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .in_data(in_data), .in_sel(in_sel), .in_bcast(in_bcast),
        .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .drop_count(drop_count)
    );

    demux_stream_n #(.WIDTH(8), .CHANNELS(6), .SEL_W(3)) dut6 (
        .clk(clk), .reset(reset), .enable(b_enable),
        .in_data(b_data), .in_sel(b_sel), .in_bcast(b_bcast),
        .in_valid(b_valid), .in_ready(b_ready),
        .out_data(b_out_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
        .drop_count(b_drop)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1; enable = 1'b1; in_bcast = 1'b0; in_valid = 1'b0;
        in_data = 8'h00; in_sel = 3'd0; out_ready = 8'h00;
        b_enable = 1'b1; b_bcast = 1'b0; b_valid = 1'b0;
        b_data = 8'h00; b_sel = 3'd0; b_out_ready = 6'h00;

        // Reset for two cycles
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'h00);
        chk("rst_out_data", out_data, 64'h0);
        chk("rst_drop", 64'(drop_count), 64'h00);
        chk("rst_in_ready", 64'(in_ready), 64'h1);
        chk("rst6_out_valid", 64'(b_out_valid), 64'h00);

        // Unicast to channel 5
        @(negedge clk);
        in_sel = 3'd5; in_data = 8'hA5; in_valid = 1'b1;
        #1 chk("uni_in_ready", 64'(in_ready), 64'h1);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        chk("uni_out_valid", 64'(out_valid), 64'h20);
        chk("uni_out_data", out_data, 64'h0000_A500_0000_0000);

        // Drain channel 5 while loading channel 2
        out_ready = 8'h20; in_sel = 3'd2; in_data = 8'h77; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; out_ready = 8'h00;
        #1;
        chk("ld2_out_valid", 64'(out_valid), 64'h04);
        chk("ld2_out_data", out_data, 64'h0000_A500_0077_0000);

        // Backpressure on channel 2
        in_sel = 3'd2; in_data = 8'h99; in_valid = 1'b1;
        #1 chk("bp_in_ready", 64'(in_ready), 64'h0);
        @(negedge clk);
        #1;
        chk("bp_out_valid", 64'(out_valid), 64'h04);
        chk("bp_out_data", out_data, 64'h0000_A500_0077_0000);

        // Release channel 2 and replace its word in the same cycle
        out_ready = 8'h04; in_data = 8'h3C;
        #1 chk("rel_in_ready", 64'(in_ready), 64'h1);
        @(negedge clk);
        in_valid = 1'b0; out_ready = 8'h00;
        #1;
        chk("rel_out_valid", 64'(out_valid), 64'h04);
        chk("rel_out_data", out_data, 64'h0000_A500_003C_0000);

        // Streaming one word per cycle across all channels
        out_ready = 8'hFF; in_valid = 1'b1;
        for (int k = 0; k < 8; k++) begin
            in_sel = 3'(k); in_data = 8'(8'h10 + k);
            #1 chk($sformatf("strm_in_ready_%0d", k), 64'(in_ready), 64'h1);
            @(negedge clk);
            #1 chk($sformatf("strm_out_valid_%0d", k), 64'(out_valid), 64'(8'h01 << k));
        end
        in_valid = 1'b0;
        @(negedge clk);
        #1;
        chk("strm_drained", 64'(out_valid), 64'h00);
        chk("strm_out_data", out_data, 64'h1716_1514_1312_1110);

        // Stall channel 7, then broadcast must wait
        out_ready = 8'h00; in_sel = 3'd7; in_data = 8'h55; in_valid = 1'b1;
        @(negedge clk);
        in_bcast = 1'b1; in_data = 8'h11;
        #1;
        chk("bc_stall_out_valid", 64'(out_valid), 64'h80);
        chk("bc_in_ready_blocked", 64'(in_ready), 64'h0);
        @(negedge clk);
        #1;
        chk("bc_no_write_valid", 64'(out_valid), 64'h80);
        chk("bc_no_write_data", out_data, 64'h5516_1514_1312_1110);
        out_ready = 8'h80;
        #1 chk("bc_in_ready_free", 64'(in_ready), 64'h1);
        @(negedge clk);
        in_valid = 1'b0; in_bcast = 1'b0; out_ready = 8'h00;
        #1;
        chk("bc_out_valid", 64'(out_valid), 64'hFF);
        chk("bc_out_data", out_data, 64'h1111_1111_1111_1111);
        out_ready = 8'hFF;
        @(negedge clk);
        out_ready = 8'h00;
        #1 chk("bc_drained", 64'(out_valid), 64'h00);

        // Out-of-range selects on the 6-channel build
        b_sel = 3'd7; b_data = 8'hC3; b_valid = 1'b1;
        #1 chk("oor_in_ready", 64'(b_ready), 64'h1);
        repeat (254) @(negedge clk);
        #1 chk("oor_drop_254", 64'(b_drop), 64'd254);
        repeat (46) @(negedge clk);
        b_valid = 1'b0;
        #1;
        chk("oor_drop_sat", 64'(b_drop), 64'd255);
        chk("oor_out_valid", 64'(b_out_valid), 64'h00);
        chk("oor_main_drop", 64'(drop_count), 64'h00);

        // Load channels 1 and 4, then drop enable
        in_sel = 3'd1; in_data = 8'h21; in_valid = 1'b1;
        @(negedge clk);
        in_sel = 3'd4; in_data = 8'h44;
        @(negedge clk);
        enable = 1'b0; in_sel = 3'd0; in_data = 8'hEE;
        #1 chk("en_in_ready", 64'(in_ready), 64'h0);
        @(negedge clk);
        #1;
        chk("en_held_valid", 64'(out_valid), 64'h12);
        chk("en_held_data", out_data, 64'h1111_1144_1111_2111);
        out_ready = 8'h12;
        @(negedge clk);
        #1;
        chk("en_drain_valid", 64'(out_valid), 64'h00);
        chk("en_in_ready_still", 64'(in_ready), 64'h0);
        enable = 1'b1; in_valid = 1'b0; out_ready = 8'h00;

        // Reset while channel 3 is stalled, with an accept offered in the reset cycle
        in_sel = 3'd3; in_data = 8'h33; in_valid = 1'b1;
        @(negedge clk);
        #1 chk("mr_pre_valid", 64'(out_valid), 64'h08);
        reset = 1'b1; in_sel = 3'd6; in_data = 8'h66;
        @(negedge clk);
        reset = 1'b0; in_valid = 1'b0;
        #1;
        chk("mr_out_valid", 64'(out_valid), 64'h00);
        chk("mr_out_data", out_data, 64'h0);
        chk("mr6_drop", 64'(b_drop), 64'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
